hit_resolver: RTL

//  Two-player combat resolver; consumes the attack-hitbox/hurtbox geometry that each player's
//  top level draws and decides when a hit lands. Once per frame it tests each attacker's
//  40x40 hitbox against the opponent's 40x45 hurtbox.
//  On a landed hit it applies damage, starts hitstun and reports knockback direction.

---
 rtl/hit_resolver.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/hit_resolver.sv
// -----------------------------------------------------------------------------
// hit_resolver
//   Two-player combat resolver. Once per frame (on the SCEN strobe) it tests
//   each attacker's 40x40 attack hitbox against the opponent's 40x45 hurtbox.
//   A landed hit removes DAMAGE health, starts HITSTUN_FRAMES frames of
//   hitstun and latches the knockback direction. A player whose health hits
//   zero is knocked out; the match result is held until reset.
//
// Ports
//   clk                  pixel clock
//   reset                asynchronous, active-high reset
//   SCEN                 frame strobe, one clk wide
//   p1_pos_x/p1_pos_y    player 1 sprite origin
//   p2_pos_x/p2_pos_y    player 2 sprite origin
//   p1_facing_right      1 = player 1 faces right (same for p2)
//   p1_attack_damage     player 1 damage window open (same for p2)
//   p1_hit/p2_hit        one-clk pulse: this player was hit this frame
//   p1_hitstun_active    player 1 in hitstun (same for p2)
//   p1_knock_right       direction of last knockback received (same for p2)
//   p1_health/p2_health  current health
//   ko                   a player has been knocked out (sticky)
//   winner               00 none, 01 P1 wins, 10 P2 wins, 11 double KO
// -----------------------------------------------------------------------------
module hit_resolver #(
  parameter int MAX_HEALTH     = 100,
  parameter int HEALTH_W       = 7,
  parameter int DAMAGE         = 10,
  parameter int HITSTUN_FRAMES = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCEN,
  input  logic [9:0]          p1_pos_x,
  input  logic [9:0]          p1_pos_y,
  input  logic [9:0]          p2_pos_x,
  input  logic [9:0]          p2_pos_y,
  input  logic                p1_facing_right,
  input  logic                p2_facing_right,
  input  logic                p1_attack_damage,
  input  logic                p2_attack_damage,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic                p1_hitstun_active,
  output logic                p2_hitstun_active,
  output logic                p1_knock_right,
  output logic                p2_knock_right,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                ko,
  output logic [1:0]          winner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HITSTUN = 2'd1,
    S_KO      = 2'd2
  } def_state_e;

  localparam int                  CNT_W       = $clog2(HITSTUN_FRAMES + 1);
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
  localparam logic [CNT_W-1:0]    STUN_INIT   = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  // Per-player views, index 0 = P1, index 1 = P2. The opponent of i is 1-i.
  logic [9:0] pos_x  [2];
  logic [9:0] pos_y  [2];
  logic [1:0] facing;
  logic [1:0] attack;

  assign pos_x[0] = p1_pos_x;
  assign pos_x[1] = p2_pos_x;
  assign pos_y[0] = p1_pos_y;
  assign pos_y[1] = p2_pos_y;
  assign facing   = {p2_facing_right, p1_facing_right};
  assign attack   = {p2_attack_damage, p1_attack_damage};

  // Defender state, indexed by the defending player.
  def_state_e          state_q  [2];
  def_state_e          state_d  [2];
  logic [CNT_W-1:0]    cnt_q    [2];
  logic [CNT_W-1:0]    cnt_d    [2];
  logic [HEALTH_W-1:0] health_q [2];
  logic [HEALTH_W-1:0] health_d [2];
  logic [HEALTH_W-1:0] hit_health [2];

  // spent is indexed by attacker; hit/knock by defender.
  logic [1:0] spent_q, spent_d;
  logic [1:0] hit_q, hit_d;
  logic [1:0] knock_q, knock_d;
  logic [1:0] winner_q, winner_d;

  logic [1:0] land;   // land[a]: attacker a lands on its opponent this SCEN
  logic       ko_now;

  // Box math is done in 12-bit signed so a left-facing hitbox near x=0 goes
  // negative instead of wrapping to a large unsigned coordinate.
  function automatic logic box_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                       input logic       af,
                                       input logic [9:0] dx, input logic [9:0] dy);
    logic signed [11:0] sax, say, sdx, sdy;
    logic signed [11:0] hx0, hx1, hy0, hy1, ux0, ux1, uy0, uy1;
    sax = $signed({2'b00, ax});
    say = $signed({2'b00, ay});
    sdx = $signed({2'b00, dx});
    sdy = $signed({2'b00, dy});
    hx0 = af ? sax + 12'sd85  : sax - 12'sd5;
    hx1 = af ? sax + 12'sd125 : sax + 12'sd35;
    hy0 = say + 12'sd55;
    hy1 = say + 12'sd95;
    ux0 = sdx + 12'sd40;
    ux1 = sdx + 12'sd80;
    uy0 = sdy + 12'sd53;
    uy1 = sdy + 12'sd98;
    // Half-open intervals: edges that merely touch do not overlap.
    return (hx0 < ux1) && (ux0 < hx1) && (hy0 < uy1) && (uy0 < hy1);
  endfunction

  assign ko_now = (state_q[0] == S_KO) || (state_q[1] == S_KO);

  always_comb begin
    land = '0;
    for (int a = 0; a < 2; a++) begin
      land[a] = SCEN && attack[a] && !spent_q[a] && !ko_now &&
                (state_q[1-a] == S_IDLE) &&
                box_overlap(pos_x[a], pos_y[a], facing[a], pos_x[1-a], pos_y[1-a]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    spent_d  = spent_q;
    hit_d    = '0;
    knock_d  = knock_q;
    winner_d = winner_q;

    for (int d = 0; d < 2; d++) begin
      state_d[d]    = state_q[d];
      cnt_d[d]      = cnt_q[d];
      health_d[d]   = health_q[d];
      hit_health[d] = (health_q[d] > DMG) ? health_q[d] - DMG : '0;

      unique case (state_q[d])
        S_IDLE: begin
          if (land[1-d]) begin
            health_d[d] = hit_health[d];
            hit_d[d]    = 1'b1;
            knock_d[d]  = facing[1-d];
            if (hit_health[d] == '0) begin
              state_d[d] = S_KO;
              cnt_d[d]   = '0;
            end else begin
              state_d[d] = S_HITSTUN;
              cnt_d[d]   = STUN_INIT;
            end
          end
        end
        S_HITSTUN: begin
          // Invulnerable here; the frame that counts down to zero is the last.
          if (SCEN) begin
            cnt_d[d] = cnt_q[d] - CNT_ONE;
            if (cnt_q[d] == CNT_ONE) state_d[d] = S_IDLE;
          end
        end
        S_KO: begin
          cnt_d[d] = '0;
        end
        default: begin
          state_d[d] = S_IDLE;
          cnt_d[d]   = '0;
        end
      endcase
    end

    // One landed hit per damage window: a window ends on a frame without it.
    for (int a = 0; a < 2; a++) begin
      if (SCEN) begin
        if (!attack[a])   spent_d[a] = 1'b0;
        else if (land[a]) spent_d[a] = 1'b1;
      end
    end

    // Result is captured on the first KO frame; a trade yields 11.
    if (winner_q == 2'b00) begin
      winner_d = {state_d[0] == S_KO, state_d[1] == S_KO};
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all state is plain flops (no RAM), so every register is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= '0;
        health_q[i] <= HEALTH_INIT;
      end
      spent_q  <= '0;
      hit_q    <= '0;
      knock_q  <= '0;
      winner_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        health_q[i] <= health_d[i];
      end
      spent_q  <= spent_d;
      hit_q    <= hit_d;
      knock_q  <= knock_d;
      winner_q <= winner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    p1_hit            = hit_q[0];
    p2_hit            = hit_q[1];
    p1_hitstun_active = (state_q[0] == S_HITSTUN);
    p2_hitstun_active = (state_q[1] == S_HITSTUN);
    p1_knock_right    = knock_q[0];
    p2_knock_right    = knock_q[1];
    p1_health         = health_q[0];
    p2_health         = health_q[1];
    ko                = ko_now;
    winner            = winner_q;
  end

endmodule
